// File: rtl/glitch_pkg.sv
// Shared types and constants for the glitch-target test sequencer.
package glitch_pkg;

    typedef enum logic [2:0] {
        GTS_IDLE,
        GTS_ISSUE,
        GTS_WAIT,
        GTS_CHECK,
        GTS_NEXT,
        GTS_DONE
    } gts_state_t;

    localparam logic [7:0]  GTS_XOR_KEY = 8'hA5;
    localparam int unsigned GTS_DATA_W  = 8;
    localparam int unsigned GTS_NUM_VEC = 16;
    localparam int unsigned GTS_TIMEOUT = 15;
    localparam int unsigned GTS_IDX_W   = 8;

    // Increment that sticks at all-ones.
    function automatic logic [7:0] gts_sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/gts_vec_gen.sv
// Deterministic operand pair and expected sum for a vector index.
module gts_vec_gen
    import glitch_pkg::*;
#(
    parameter int unsigned DATA_W = GTS_DATA_W
) (
    input  logic [GTS_IDX_W-1:0] idx,
    output logic [DATA_W-1:0]    op_a_c,
    output logic [DATA_W-1:0]    op_b_c,
    output logic [DATA_W-1:0]    sum_c
);

    always_comb begin
        op_a_c = DATA_W'(idx);
        op_b_c = DATA_W'(idx ^ GTS_XOR_KEY);
        sum_c  = op_a_c + op_b_c;
    end

endmodule

// File: rtl/glitch_test_sequencer.sv
// Issues one vector at a time to the glitch-target adder, checks each result
// and keeps fault/timeout/spurious-valid statistics for the run.
module glitch_test_sequencer
    import glitch_pkg::*;
#(
    parameter int unsigned DATA_W  = GTS_DATA_W,
    parameter int unsigned NUM_VEC = GTS_NUM_VEC,
    parameter int unsigned TIMEOUT = GTS_TIMEOUT
) (
    input  logic              glitched_clk,
    input  logic              rst,
    input  logic              start,
    output logic [DATA_W-1:0] op_a,
    output logic [DATA_W-1:0] op_b,
    output logic              DV_1,
    input  logic [DATA_W-1:0] finout,
    input  logic              DV_3,
    output logic              busy,
    output logic              done,
    output logic              fault_valid,
    output logic [7:0]        fault_idx,
    output logic [DATA_W-1:0] fault_data,
    output logic [7:0]        fault_cnt,
    output logic              spurious,
    output logic              timeout_err
);

    localparam int unsigned            WAIT_W     = $clog2(TIMEOUT + 1);
    localparam logic [GTS_IDX_W-1:0]   LAST_IDX   = GTS_IDX_W'(NUM_VEC - 1);
    localparam logic [WAIT_W-1:0]      WAIT_LIMIT = WAIT_W'(TIMEOUT);

    gts_state_t             state, state_d;
    logic [GTS_IDX_W-1:0]   idx, idx_d, gen_idx;
    logic [WAIT_W-1:0]      wait_cnt, wait_d, wait_inc;
    logic [DATA_W-1:0]      expected, exp_d, captured, cap_d;
    logic [DATA_W-1:0]      gen_a, gen_b, gen_sum;
    logic [DATA_W-1:0]      op_a_d, op_b_d, fdata_d;
    logic [7:0]             fidx_d, fcnt_d;
    logic                   dv_1_d, busy_d, done_d, fv_d, spur_d, to_d;

    // Index of the vector about to be issued (entry to ISSUE from IDLE or NEXT).
    assign gen_idx  = (state == GTS_IDLE) ? '0 : idx + GTS_IDX_W'(1);
    assign wait_inc = wait_cnt + WAIT_W'(1);

    gts_vec_gen #(.DATA_W(DATA_W)) u_vec_gen (
        .idx    (gen_idx),
        .op_a_c (gen_a),
        .op_b_c (gen_b),
        .sum_c  (gen_sum)
    );

    always_ff @(posedge glitched_clk) begin
        if (!rst) begin
            state       <= GTS_IDLE;
            idx         <= '0;
            wait_cnt    <= '0;
            expected    <= '0;
            captured    <= '0;
            op_a        <= '0;
            op_b        <= '0;
            DV_1        <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            fault_valid <= 1'b0;
            fault_idx   <= '0;
            fault_data  <= '0;
            fault_cnt   <= '0;
            spurious    <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_d;
            idx         <= idx_d;
            wait_cnt    <= wait_d;
            expected    <= exp_d;
            captured    <= cap_d;
            op_a        <= op_a_d;
            op_b        <= op_b_d;
            DV_1        <= dv_1_d;
            busy        <= busy_d;
            done        <= done_d;
            fault_valid <= fv_d;
            fault_idx   <= fidx_d;
            fault_data  <= fdata_d;
            fault_cnt   <= fcnt_d;
            spurious    <= spur_d;
            timeout_err <= to_d;
        end
    end

    // Next-state and next-output logic; outputs are the registered *_d values.
    always_comb begin
        state_d = state;
        idx_d   = idx;
        wait_d  = wait_cnt;
        exp_d   = expected;
        cap_d   = captured;
        op_a_d  = op_a;
        op_b_d  = op_b;
        dv_1_d  = 1'b0;
        done_d  = 1'b0;
        fv_d    = 1'b0;
        fidx_d  = fault_idx;
        fdata_d = fault_data;
        fcnt_d  = fault_cnt;
        spur_d  = spurious;
        to_d    = timeout_err;

        case (state)
            GTS_IDLE: begin
                if (start) begin
                    fcnt_d  = '0;
                    fidx_d  = '0;
                    fdata_d = '0;
                    spur_d  = 1'b0;
                    to_d    = 1'b0;
                    idx_d   = '0;
                    dv_1_d  = 1'b1;
                    op_a_d  = gen_a;
                    op_b_d  = gen_b;
                    exp_d   = gen_sum;
                    state_d = GTS_ISSUE;
                end
            end
            GTS_ISSUE: begin
                wait_d  = '0;
                state_d = GTS_WAIT;
            end
            GTS_WAIT: begin
                // An arrival on the last wait cycle beats the timeout.
                if (DV_3) begin
                    cap_d   = finout;
                    state_d = GTS_CHECK;
                end else begin
                    wait_d = wait_inc;
                    if (wait_inc == WAIT_LIMIT) begin
                        fv_d    = 1'b1;
                        fidx_d  = 8'(idx);
                        fdata_d = '0;
                        fcnt_d  = gts_sat_inc(fault_cnt);
                        to_d    = 1'b1;
                        state_d = GTS_NEXT;
                    end
                end
            end
            GTS_CHECK: begin
                if (captured != expected) begin
                    fv_d    = 1'b1;
                    fidx_d  = 8'(idx);
                    fdata_d = captured;
                    fcnt_d  = gts_sat_inc(fault_cnt);
                end
                state_d = GTS_NEXT;
            end
            GTS_NEXT: begin
                if (idx == LAST_IDX) begin
                    done_d  = 1'b1;
                    state_d = GTS_DONE;
                end else begin
                    idx_d   = gen_idx;
                    dv_1_d  = 1'b1;
                    op_a_d  = gen_a;
                    op_b_d  = gen_b;
                    exp_d   = gen_sum;
                    state_d = GTS_ISSUE;
                end
            end
            GTS_DONE: begin
                state_d = GTS_IDLE;
            end
            default: begin
                state_d = GTS_IDLE;
            end
        endcase

        if (DV_3 && (state != GTS_WAIT)) begin
            spur_d = 1'b1;
        end

        busy_d = (state_d != GTS_IDLE);
    end

endmodule

// File: tb/tb_glitch_test_sequencer.sv
// Bench for glitch_test_sequencer: ideal 2-stage adder models, scenario table,
// operand/fault scoreboards and hand-written corner sequences.
module tb_glitch_test_sequencer;

    localparam int unsigned DW   = 8;
    localparam int unsigned NV   = 16;
    localparam int unsigned TO   = 15;
    localparam int unsigned NV_S = 256;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst, start, start_s, inject;
    logic [DW-1:0]   op_a, op_b, finout, fault_data;
    logic [7:0]      fault_idx, fault_cnt;
    logic            dv_1, dv_3, busy, done, fault_valid, spurious, timeout_err;
    logic [DW-1:0]   op_a_s, op_b_s, finout_s, fault_data_s;
    logic [7:0]      fault_idx_s, fault_cnt_s;
    logic            dv_1_s, dv_3_s, busy_s, done_s, fault_valid_s, spurious_s, timeout_err_s;

    // Behaviour knobs of the pipeline model for the main DUT
    logic            corr_en, drop_en;
    logic [7:0]      corr_idx, drop_idx;

    glitch_test_sequencer #(.DATA_W(DW), .NUM_VEC(NV), .TIMEOUT(TO)) dut (
        .glitched_clk(clk), .rst(rst), .start(start), .op_a(op_a), .op_b(op_b),
        .DV_1(dv_1), .finout(finout), .DV_3(dv_3), .busy(busy), .done(done),
        .fault_valid(fault_valid), .fault_idx(fault_idx), .fault_data(fault_data),
        .fault_cnt(fault_cnt), .spurious(spurious), .timeout_err(timeout_err)
    );

    glitch_test_sequencer #(.DATA_W(DW), .NUM_VEC(NV_S), .TIMEOUT(TO)) dut_s (
        .glitched_clk(clk), .rst(rst), .start(start_s), .op_a(op_a_s), .op_b(op_b_s),
        .DV_1(dv_1_s), .finout(finout_s), .DV_3(dv_3_s), .busy(busy_s), .done(done_s),
        .fault_valid(fault_valid_s), .fault_idx(fault_idx_s), .fault_data(fault_data_s),
        .fault_cnt(fault_cnt_s), .spurious(spurious_s), .timeout_err(timeout_err_s)
    );

    // Ideal operand stage + result stage, with optional corruption/drop.
    logic          s1_v, dv3_q;
    logic [7:0]    s1_a, s1_b, fin_q;
    always @(posedge clk) begin
        if (!rst) begin
            s1_v <= 1'b0; s1_a <= '0; s1_b <= '0; dv3_q <= 1'b0; fin_q <= '0;
        end else begin
            s1_v  <= dv_1 && !(drop_en && op_a == drop_idx);
            s1_a  <= op_a;
            s1_b  <= op_b;
            dv3_q <= s1_v;
            fin_q <= (corr_en && s1_a == corr_idx) ? 8'h00 : 8'(s1_a + s1_b);
        end
    end
    assign dv_3   = dv3_q | inject;
    assign finout = fin_q;

    // Always-wrong pipeline for the saturation instance.
    logic          s1_v_s, dv3_q_s;
    logic [7:0]    s1_a_s, s1_b_s, fin_q_s;
    always @(posedge clk) begin
        if (!rst) begin
            s1_v_s <= 1'b0; s1_a_s <= '0; s1_b_s <= '0; dv3_q_s <= 1'b0; fin_q_s <= '0;
        end else begin
            s1_v_s  <= dv_1_s;
            s1_a_s  <= op_a_s;
            s1_b_s  <= op_b_s;
            dv3_q_s <= s1_v_s;
            fin_q_s <= ~8'(s1_a_s + s1_b_s);
        end
    end
    assign dv_3_s   = dv3_q_s;
    assign finout_s = fin_q_s;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s", name);
    endtask

    // Scoreboards
    typedef struct packed { logic [7:0] a; logic [7:0] b; } ops_t;
    typedef struct packed { logic [7:0] idx; logic [7:0] data; } flt_t;
    ops_t op_q[$];
    flt_t flt_q[$];
    ops_t mon_op;
    flt_t mon_flt;
    int   dv1_seen, fv_seen, fv_s_seen;

    always @(negedge clk) begin
        if (dv_1) begin
            dv1_seen++;
            if (op_q.size() == 0) fail("dv1_unexpected");
            else begin
                mon_op = op_q.pop_front();
                check("op_a", 32'(op_a), 32'(mon_op.a));
                check("op_b", 32'(op_b), 32'(mon_op.b));
            end
        end
        if (fault_valid) begin
            fv_seen++;
            if (flt_q.size() == 0) fail("fault_valid_unexpected");
            else begin
                mon_flt = flt_q.pop_front();
                check("fault_idx_pulse", 32'(fault_idx), 32'(mon_flt.idx));
                check("fault_data_pulse", 32'(fault_data), 32'(mon_flt.data));
                check("fault_cnt_pulse", 32'(fault_cnt), 32'(fv_seen));
            end
        end
        if (fault_valid_s) begin
            check("sat_fault_idx", 32'(fault_idx_s), 32'(fv_s_seen & 255));
            fv_s_seen++;
            check("sat_fault_cnt", 32'(fault_cnt_s), (fv_s_seen >= 255) ? 32'd255 : 32'(fv_s_seen));
        end
    end

    task automatic start_run(output int t0);
        @(negedge clk);
        for (int i = 0; i < int'(NV); i++) begin
            op_q.push_back('{a: 8'(i), b: 8'(i) ^ 8'hA5});
        end
        dv1_seen = 0;
        fv_seen  = 0;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        t0    = cyc;
    endtask

    // Cycle count from the start-sampling cycle (cycle 0) to the done cycle.
    task automatic wait_done(input int t0, output int lat);
        while (!done && (cyc - t0) < 400) @(negedge clk);
        if (done) lat = cyc - t0 + 1;
        else begin
            fail("done_timeout");
            lat = -1;
        end
    endtask

    task automatic wait_issue(input logic [7:0] which);
        int n = 0;
        while (!(dv_1 && op_a == which) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) fail("issue_timeout");
    endtask

    typedef struct {
        logic       corr_en;
        logic [7:0] corr_idx;
        logic       drop_en;
        logic [7:0] drop_idx;
        int         lat;
        logic [7:0] cnt;
        logic       to;
        logic [7:0] fidx;
        logic [7:0] fdata;
    } scen_t;
    scen_t tbl[5];

    int t0, lat, n;
    logic saw_bad;
    logic [7:0] la, lb, lexp;

    initial begin
        tbl[0] = '{1'b0, 8'd0,  1'b0, 8'd0, 81, 8'd0, 1'b0, 8'd0,  8'd0};
        tbl[1] = '{1'b1, 8'd5,  1'b0, 8'd0, 81, 8'd1, 1'b0, 8'd5,  8'd0};
        tbl[2] = '{1'b0, 8'd0,  1'b1, 8'd3, 93, 8'd1, 1'b1, 8'd3,  8'd0};
        tbl[3] = '{1'b1, 8'd15, 1'b0, 8'd0, 81, 8'd1, 1'b0, 8'd15, 8'd0};
        tbl[4] = '{1'b0, 8'd0,  1'b1, 8'd0, 93, 8'd1, 1'b1, 8'd0,  8'd0};

        rst = 1'b0; start = 1'b0; start_s = 1'b0; inject = 1'b0;
        corr_en = 1'b0; drop_en = 1'b0; corr_idx = '0; drop_idx = '0;
        dv1_seen = 0; fv_seen = 0; fv_s_seen = 0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_dv1", 32'(dv_1), 0);
        check("rst_op_a", 32'(op_a), 0);
        check("rst_fault_cnt", 32'(fault_cnt), 0);
        check("rst_spurious", 32'(spurious), 0);
        rst = 1'b1;
        @(negedge clk);

        for (int s = 0; s < 5; s++) begin
            corr_en = tbl[s].corr_en; corr_idx = tbl[s].corr_idx;
            drop_en = tbl[s].drop_en; drop_idx = tbl[s].drop_idx;
            if (tbl[s].corr_en) flt_q.push_back('{idx: tbl[s].corr_idx, data: 8'h00});
            if (tbl[s].drop_en) flt_q.push_back('{idx: tbl[s].drop_idx, data: 8'h00});
            start_run(t0);
            wait_done(t0, lat);
            check($sformatf("s%0d_latency", s), 32'(lat), 32'(tbl[s].lat));
            check($sformatf("s%0d_fault_cnt", s), 32'(fault_cnt), 32'(tbl[s].cnt));
            check($sformatf("s%0d_timeout_err", s), 32'(timeout_err), 32'(tbl[s].to));
            check($sformatf("s%0d_fault_idx", s), 32'(fault_idx), 32'(tbl[s].fidx));
            check($sformatf("s%0d_fault_data", s), 32'(fault_data), 32'(tbl[s].fdata));
            check($sformatf("s%0d_spurious", s), 32'(spurious), 0);
            check($sformatf("s%0d_dv1_count", s), 32'(dv1_seen), 32'(NV));
            check($sformatf("s%0d_fv_count", s), 32'(fv_seen), 32'(tbl[s].cnt));
            check($sformatf("s%0d_sb_empty", s), 32'(op_q.size() + flt_q.size()), 0);
            @(negedge clk);
            check($sformatf("s%0d_done_pulse", s), 32'(done), 0);
            check($sformatf("s%0d_busy_after", s), 32'(busy), 0);
        end
        corr_en = 1'b0; drop_en = 1'b0;

        // Result dropped for idx 4 but a valid arrives on the final wait cycle.
        drop_en = 1'b1; drop_idx = 8'd4;
        start_run(t0);
        wait_issue(8'd4);
        repeat (15) @(negedge clk);
        inject = 1'b1;
        @(negedge clk);
        inject = 1'b0;
        wait_done(t0, lat);
        check("tie_latency", 32'(lat), 94);
        check("tie_timeout_err", 32'(timeout_err), 0);
        check("tie_fault_cnt", 32'(fault_cnt), 0);
        check("tie_spurious", 32'(spurious), 0);
        drop_en = 1'b0;
        @(negedge clk);

        // Extra valid during CHECK of idx 2 and start re-pulsed mid-run.
        start_run(t0);
        wait_issue(8'd2);
        repeat (3) @(negedge clk);
        inject = 1'b1; start = 1'b1;
        @(negedge clk);
        inject = 1'b0; start = 1'b0;
        wait_done(t0, lat);
        check("spur_latency", 32'(lat), 81);
        check("spur_flag", 32'(spurious), 1);
        check("spur_fault_cnt", 32'(fault_cnt), 0);
        check("spur_timeout_err", 32'(timeout_err), 0);
        repeat (6) @(negedge clk);
        check("spur_no_restart_busy", 32'(busy), 0);
        check("spur_dv1_count", 32'(dv1_seen), 32'(NV));

        // Reset pulse during WAIT of idx 7 aborts the run.
        corr_en = 1'b1; corr_idx = 8'd2;
        flt_q.push_back('{idx: 8'd2, data: 8'h00});
        start_run(t0);
        wait_issue(8'd7);
        @(negedge clk);
        check("pre_rst_fault_cnt", 32'(fault_cnt), 1);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_fault_cnt", 32'(fault_cnt), 0);
        check("mid_rst_fault_idx", 32'(fault_idx), 0);
        check("mid_rst_op_a", 32'(op_a), 0);
        check("mid_rst_op_b", 32'(op_b), 0);
        check("mid_rst_flags", 32'({spurious, timeout_err, fault_valid, done, dv_1}), 0);
        op_q.delete();
        saw_bad = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (done || fault_valid || dv_1) saw_bad = 1'b1;
        end
        check("mid_rst_quiet", 32'(saw_bad), 0);
        check("mid_rst_flt_q_empty", 32'(flt_q.size()), 0);
        corr_en = 1'b0;
        start_run(t0);
        wait_done(t0, lat);
        check("post_rst_latency", 32'(lat), 81);
        check("post_rst_fault_cnt", 32'(fault_cnt), 0);
        check("post_rst_dv1_count", 32'(dv1_seen), 32'(NV));
        @(negedge clk);

        // 256-vector run against an always-wrong pipeline.
        fv_s_seen = 0;
        start_s = 1'b1;
        @(negedge clk);
        start_s = 1'b0;
        t0 = cyc;
        n  = 0;
        while (!done_s && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!done_s) fail("sat_done_timeout");
        check("sat_latency", 32'(cyc - t0 + 1), 32'(NV_S * 5 + 1));
        check("sat_cnt_final", 32'(fault_cnt_s), 255);
        check("sat_pulses", 32'(fv_s_seen), 256);
        check("sat_last_idx", 32'(fault_idx_s), 255);
        la   = 8'hFF;
        lb   = la ^ 8'hA5;
        lexp = ~8'(la + lb);
        check("sat_last_data", 32'(fault_data_s), 32'(lexp));
        check("sat_timeout_err", 32'(timeout_err_s), 0);
        check("sat_spurious", 32'(spurious_s), 0);
        @(negedge clk);
        check("sat_busy_after", 32'(busy_s), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
